fmc_master: RTL and testbench
=============================

Name: fmc_master

Overview:
- Synchronous FMC bus initiator: issues single-address, fixed-length burst reads and writes on the same FMC bus that our FMC-to-BRAM bridge responds to.
- Used as the bench/loopback host and as the FPGA-side master when one of our boards drives another board's bridge.
- A command port starts a burst.
- A pull-style write-data port and a push-style read-data port carry the beats.
- The bus has no wait signal, so once started, beats are never stalled.

Parameters:
- FMC_AW, 20, FMC address width (word address).
- DW, 32, data width.
- LEN_W, 8, burst length field width; max burst 2^LEN_W beats.
- WR_LAT, 3, cycles from fmc_ne assertion (cycle 0) to first write beat.
- RD_LAT, 3, cycles from fmc_ne assertion (cycle 0) to first read sample.
- GAP, 1, minimum fmc_ne-high cycles between bursts (>=1).

Ports:
- fmc_clk, in, 1: clock; all logic on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- cmd_valid, in, 1: command request.
- cmd_ready, out, 1: command accepted when cmd_valid & cmd_ready.
- cmd_write, in, 1: 1 = write burst, 0 = read burst.
- cmd_addr, in, FMC_AW: start word address.
- cmd_len, in, LEN_W: beats minus 1.
- wr_ready, out, 1: beat strobe; wr_data consumed this cycle.
- wr_valid, in, 1: wr_data valid.
- wr_data, in, DW: write beat data.
- rd_valid, out, 1: rd_data valid, one-cycle pulse per beat.
- rd_data, out, DW: read beat data.
- busy, out, 1: high from command accept through end of GAP.
- underrun, out, 1: sticky write-underrun flag.
- fmc_a, out, FMC_AW: bus address.
- fmc_d, inout, DW: bus data.
- fmc_ne, out, 1: chip enable, active low.
- fmc_noe, out, 1: output enable, active low.
- fmc_nwe, out, 1: write enable, active low.

Behaviour:
- Reset (async, rst_n=0), effective immediately, including mid-burst:
  - fmc_ne = fmc_noe = fmc_nwe = 1; fmc_a = 0; fmc_d hi-Z.
  - cmd_ready = 1; wr_ready = rd_valid = busy = underrun = 0; rd_data = 0.
  - FSM to IDLE; no partial-burst completion after release.
- States: IDLE, LAT, DATA, GAP.
- IDLE:
  - cmd_ready = 1.
  - On accept: latch write/addr/len, clear underrun, assert busy.
  - Next cycle (bus cycle 0): enter LAT with fmc_ne=0 and fmc_a=addr.
  - fmc_nwe = !write; fmc_noe = write.
- fmc_a, fmc_nwe and fmc_noe are registered and held constant for the whole burst. The responder increments its address internally; the master never changes fmc_a mid-burst.
- LAT: a counter runs from cycle 0 up to WR_LAT-1 (write) or RD_LAT-1 (read), then the FSM enters DATA at cycle WR_LAT/RD_LAT.
- DATA (write):
  - For len+1 consecutive cycles, fmc_d is driven with the beat data.
  - wr_ready is asserted one cycle before each bus beat, so the data can be registered onto fmc_d.
  - If wr_valid=0 while wr_ready=1, the previous beat's data is repeated on the bus and underrun sets.
  - The burst is never stretched or aborted.
  - fmc_d is driven only in DATA while writing; hi-Z otherwise.
- DATA (read):
  - fmc_d is sampled at the end of each of len+1 consecutive cycles.
  - rd_data/rd_valid are registered, appearing the cycle after the sample.
  - The consumer cannot backpressure.
- The last beat cycle is the final cycle with fmc_ne=0. The next cycle drives fmc_ne=fmc_noe=fmc_nwe=1 and fmc_d hi-Z, entering GAP.
- GAP:
  - Holds GAP cycles; cmd_ready=0.
  - Then IDLE; busy drops the same cycle cmd_ready rises.
  - A command held valid during GAP is accepted on the first IDLE cycle.
- cmd_len=0 gives a single beat. cmd_len=2^LEN_W-1 gives the max burst; the beat counter must not wrap early.
- cmd_valid with busy=1 is ignored, with no queueing. The held command is taken when cmd_ready rises.
- underrun is cleared only by reset or the next command accept.

Test Plan:
- Write: cmd addr=0x00010, len=3, write; wr_data 0xA0..0xA3 always valid -> fmc_ne low exactly 3+4=7 cycles, fmc_a=0x00010 constant, fmc_nwe=0, fmc_d=0xA0,0xA1,0xA2,0xA3 on cycles 3..6, underrun=0.
- Read vs behavioural responder returning addr+0x100: addr=0x00020, len=1 -> fmc_noe=0, two rd_valid pulses with rd_data=0x120,0x121, fmc_d never driven by master.
- Back-to-back: read command held valid during a write burst -> accepted first IDLE cycle after GAP, fmc_ne high for exactly GAP+1 cycles between bursts.
- Underrun: len=3 write, wr_valid=0 on third wr_ready -> bus shows 0xA0,0xA1,0xA1,0xA3, underrun=1, cleared on next accept.
- Async reset mid-burst: rst_n low at cycle 4 of 8-beat write -> same cycle fmc_ne=1, fmc_d hi-Z; after release cmd_ready=1, busy=0.
- len=0 and len=255: 1 beat and 256 beats respectively, fmc_ne low for RD_LAT+1 and RD_LAT+256 cycles.

Source files
------------

// File: rtl/fmc_master.sv
// Synchronous FMC bus initiator: single-address, fixed-length burst reads and writes.
// Beats are never stalled once a burst starts; write underruns repeat the previous beat.
module fmc_master #(
    parameter int unsigned FMC_AW = 20,
    parameter int unsigned DW     = 32,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned WR_LAT = 3,
    parameter int unsigned RD_LAT = 3,
    parameter int unsigned GAP    = 1
) (
    input  logic              fmc_clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [FMC_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              wr_ready,
    input  logic              wr_valid,
    input  logic [DW-1:0]     wr_data,
    output logic              rd_valid,
    output logic [DW-1:0]     rd_data,
    output logic              busy,
    output logic              underrun,
    output logic [FMC_AW-1:0] fmc_a,
    inout  wire  [DW-1:0]     fmc_d,
    output logic              fmc_ne,
    output logic              fmc_noe,
    output logic              fmc_nwe
);

    localparam int unsigned MAX_LAT = (WR_LAT > RD_LAT) ? WR_LAT : RD_LAT;
    localparam int unsigned CYC_W   = LEN_W + $clog2(MAX_LAT + GAP + 1) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LAT  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        r_state, w_state;
    logic [CYC_W-1:0]  r_cyc, w_cyc;
    logic              r_write, w_write;
    logic [LEN_W-1:0]  r_len, w_len;
    logic [FMC_AW-1:0] r_a, w_a;
    logic              r_ne, w_ne;
    logic              r_noe, w_noe;
    logic              r_nwe, w_nwe;
    logic              r_cmd_ready, w_cmd_ready;
    logic              r_busy, w_busy;
    logic              r_underrun, w_underrun;
    logic              r_wr_ready, w_wr_ready;
    logic              r_oe, w_oe;
    logic [DW-1:0]     r_wdata, w_wdata;
    logic              r_rd_valid, w_rd_valid;
    logic [DW-1:0]     r_rd_data, w_rd_data;

    logic              w_nb;
    logic [CYC_W-1:0]  w_nc;
    logic              w_b_write;
    logic [LEN_W-1:0]  w_b_len;
    logic [CYC_W-1:0]  w_lat;
    logic [CYC_W-1:0]  w_last;

    // Burst parameters: live command while idle, latched copy once running.
    assign w_b_write = (r_state == S_IDLE) ? cmd_write : r_write;
    assign w_b_len   = (r_state == S_IDLE) ? cmd_len   : r_len;
    assign w_lat     = w_b_write ? CYC_W'(WR_LAT) : CYC_W'(RD_LAT);
    assign w_last    = w_lat + CYC_W'(w_b_len);

    always_comb begin
        w_state     = r_state;
        w_cyc       = r_cyc;
        w_write     = r_write;
        w_len       = r_len;
        w_a         = r_a;
        w_ne        = 1'b1;
        w_noe       = 1'b1;
        w_nwe       = 1'b1;
        w_cmd_ready = 1'b0;
        w_busy      = r_busy;
        w_underrun  = r_underrun;
        w_wr_ready  = 1'b0;
        w_oe        = 1'b0;
        w_wdata     = r_wdata;
        w_rd_valid  = 1'b0;
        w_rd_data   = r_rd_data;
        w_nb        = 1'b0;
        w_nc        = r_cyc + CYC_W'(1);

        // A missing beat keeps the previous data on the bus.
        if (r_wr_ready) begin
            if (wr_valid) begin
                w_wdata = wr_data;
            end else begin
                w_underrun = 1'b1;
            end
        end

        if (r_state == S_DATA && !r_write) begin
            w_rd_valid = 1'b1;
            w_rd_data  = fmc_d;
        end

        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_write     = cmd_write;
                    w_len       = cmd_len;
                    w_a         = cmd_addr;
                    w_underrun  = 1'b0;
                    w_busy      = 1'b1;
                    w_cmd_ready = 1'b0;
                    w_state     = S_LAT;
                    w_cyc       = '0;
                    w_nc        = '0;
                    w_nb        = 1'b1;
                    w_ne        = 1'b0;
                    w_nwe       = !cmd_write;
                    w_noe       = cmd_write;
                end
            end
            S_LAT, S_DATA: begin
                if (r_cyc == w_last) begin
                    w_state = S_GAP;
                    w_cyc   = '0;
                end else begin
                    w_nb    = 1'b1;
                    w_cyc   = w_nc;
                    w_ne    = 1'b0;
                    w_nwe   = r_nwe;
                    w_noe   = r_noe;
                    w_state = (w_nc >= w_lat) ? S_DATA : S_LAT;
                end
            end
            S_GAP: begin
                if (r_cyc == CYC_W'(GAP - 1)) begin
                    w_state     = S_IDLE;
                    w_cmd_ready = 1'b1;
                    w_busy      = 1'b0;
                    w_cyc       = '0;
                end else begin
                    w_cyc = w_nc;
                end
            end
            default: begin
                w_state     = S_IDLE;
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
                w_cyc       = '0;
            end
        endcase

        // wr_ready leads each bus beat by one cycle so the beat can be registered.
        if (w_nb && w_b_write) begin
            w_wr_ready = ((w_nc + CYC_W'(1)) >= w_lat) && (w_nc < w_last);
            w_oe       = (w_nc >= w_lat);
        end
    end

    always_ff @(posedge fmc_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cyc       <= '0;
            r_write     <= 1'b0;
            r_len       <= '0;
            r_a         <= '0;
            r_ne        <= 1'b1;
            r_noe       <= 1'b1;
            r_nwe       <= 1'b1;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_oe        <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_state     <= w_state;
            r_cyc       <= w_cyc;
            r_write     <= w_write;
            r_len       <= w_len;
            r_a         <= w_a;
            r_ne        <= w_ne;
            r_noe       <= w_noe;
            r_nwe       <= w_nwe;
            r_cmd_ready <= w_cmd_ready;
            r_busy      <= w_busy;
            r_underrun  <= w_underrun;
            r_wr_ready  <= w_wr_ready;
            r_oe        <= w_oe;
            r_rd_valid  <= w_rd_valid;
            r_rd_data   <= w_rd_data;
        end
    end

    // Write-beat datapath register; only meaningful while r_oe is set.
    always_ff @(posedge fmc_clk) begin
        r_wdata <= w_wdata;
    end

    assign fmc_d     = r_oe ? r_wdata : {DW{1'bz}};
    assign fmc_a     = r_a;
    assign fmc_ne    = r_ne;
    assign fmc_noe   = r_noe;
    assign fmc_nwe   = r_nwe;
    assign cmd_ready = r_cmd_ready;
    assign busy      = r_busy;
    assign underrun  = r_underrun;
    assign wr_ready  = r_wr_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

endmodule

// File: tb/tb_fmc_master.sv
// Directed bench for fmc_master with a behavioural FMC responder returning addr+0x100+beat.
module tb_fmc_master;

    localparam int unsigned FMC_AW = 20;
    localparam int unsigned DW     = 32;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned WR_LAT = 3;
    localparam int unsigned RD_LAT = 3;
    localparam int unsigned GAP    = 1;

    logic              fmc_clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [FMC_AW-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              wr_ready;
    logic              wr_valid;
    logic [DW-1:0]     wr_data;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic              busy;
    logic              underrun;
    logic [FMC_AW-1:0] fmc_a;
    wire  [DW-1:0]     fmc_d;
    logic              fmc_ne;
    logic              fmc_noe;
    logic              fmc_nwe;

    fmc_master #(
        .FMC_AW(FMC_AW), .DW(DW), .LEN_W(LEN_W),
        .WR_LAT(WR_LAT), .RD_LAT(RD_LAT), .GAP(GAP)
    ) dut (
        .fmc_clk(fmc_clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_ready(wr_ready), .wr_valid(wr_valid), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .underrun(underrun),
        .fmc_a(fmc_a), .fmc_d(fmc_d),
        .fmc_ne(fmc_ne), .fmc_noe(fmc_noe), .fmc_nwe(fmc_nwe)
    );

    initial fmc_clk = 1'b0;
    always #5 fmc_clk = ~fmc_clk;

    // Responder: counts cycles since fmc_ne fell, drives data from RD_LAT on.
    int          resp_cnt;
    logic        resp_oe;
    logic [DW-1:0] resp_data;
    always @(posedge fmc_clk or negedge rst_n) begin
        if (!rst_n)       resp_cnt <= 0;
        else if (!fmc_ne) resp_cnt <= resp_cnt + 1;
        else              resp_cnt <= 0;
    end
    assign resp_oe   = !fmc_ne && !fmc_noe && (resp_cnt >= int'(RD_LAT));
    assign resp_data = 32'h100 + 32'(fmc_a) + 32'(resp_cnt - int'(RD_LAT));
    assign fmc_d     = resp_oe ? resp_data : {DW{1'bz}};

    int n_checks;
    int n_errors;

    int ne_low, a_bad, ctl_bad, hi_run, n_acc, rdy_seen, skip_idx;
    bit seen_low, last_ne, prev_rdy, chk_ctl;
    int unsigned wr_base;
    logic [FMC_AW-1:0] exp_a;
    logic exp_nwe, exp_noe;
    logic [DW-1:0] wq[$];
    logic [DW-1:0] rq[$];
    int gap_q[$];

    // Undriven bus may read as z or 0 depending on the simulator.
    function automatic bit driven(input logic [DW-1:0] v);
        return (v !== {DW{1'bz}}) && (v !== {DW{1'b0}});
    endfunction

    task automatic clear_mon();
        ne_low = 0; a_bad = 0; ctl_bad = 0; hi_run = 0; n_acc = 0;
        rdy_seen = 0; skip_idx = -1; seen_low = 0; last_ne = 1;
        chk_ctl = 1; wr_base = 32'hA0;
        wq.delete(); rq.delete(); gap_q.delete();
    endtask

    task automatic issue(input logic wr, input logic [FMC_AW-1:0] a, input logic [LEN_W-1:0] l);
        cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
        prev_rdy = cmd_ready; exp_a = a; exp_nwe = !wr; exp_noe = wr;
    endtask

    // Advance n cycles; sample and drive at each falling edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge fmc_clk);
            if (cmd_valid && prev_rdy) begin
                cmd_valid = 1'b0;
                n_acc++;
            end
            if (!fmc_ne) begin
                if (last_ne && seen_low) gap_q.push_back(hi_run);
                seen_low = 1; hi_run = 0; ne_low++;
                if (chk_ctl && fmc_a !== exp_a) a_bad++;
                if (chk_ctl && (fmc_nwe !== exp_nwe || fmc_noe !== exp_noe)) ctl_bad++;
            end else begin
                hi_run++;
            end
            last_ne = fmc_ne;
            if (driven(fmc_d) && !resp_oe) wq.push_back(fmc_d);
            if (rd_valid) rq.push_back(rd_data);
            if (wr_ready) begin
                wr_valid = (rdy_seen != skip_idx);
                wr_data  = DW'(wr_base + 32'(rdy_seen));
                rdy_seen++;
            end else begin
                wr_valid = 1'b0;
            end
            prev_rdy = cmd_ready;
        end
    endtask

    task automatic test_reset();
        cyc(2);
        n_checks++;
        if ({fmc_ne, fmc_noe, fmc_nwe} !== 3'b111) begin n_errors++; $display("FAIL reset_ctl: got %b expected 111", {fmc_ne, fmc_noe, fmc_nwe}); end
        n_checks++;
        if (fmc_a !== '0 || driven(fmc_d)) begin n_errors++; $display("FAIL reset_bus: a=%h d=%h expected a=0 d=z", fmc_a, fmc_d); end
        n_checks++;
        if ({cmd_ready, wr_ready, rd_valid, busy, underrun} !== 5'b10000) begin n_errors++; $display("FAIL reset_flags: got %b expected 10000", {cmd_ready, wr_ready, rd_valid, busy, underrun}); end
        n_checks++;
        if (rd_data !== '0) begin n_errors++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        rst_n = 1'b1;
        cyc(2);
    endtask

    task automatic test_write();
        clear_mon();
        issue(1'b1, 20'h00010, 8'd3);
        cyc(2);
        n_checks++;
        if ({busy, cmd_ready} !== 2'b10) begin n_errors++; $display("FAIL wr_busy: busy,ready=%b expected 10", {busy, cmd_ready}); end
        cyc(14);
        n_checks++;
        if (ne_low !== 7) begin n_errors++; $display("FAIL wr_ne_low: got %0d expected 7", ne_low); end
        n_checks++;
        if (a_bad !== 0 || ctl_bad !== 0) begin n_errors++; $display("FAIL wr_addr_ctl: a_bad=%0d ctl_bad=%0d expected 0", a_bad, ctl_bad); end
        n_checks++;
        if (wq.size() !== 4) begin n_errors++; $display("FAIL wr_beats: got %0d expected 4", wq.size()); end
        else for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (wq[i] !== DW'(32'hA0 + 32'(i))) begin n_errors++; $display("FAIL wr_data%0d: got %h expected %h", i, wq[i], 32'hA0 + 32'(i)); end
        end
        n_checks++;
        if ({underrun, busy, cmd_ready} !== 3'b001) begin n_errors++; $display("FAIL wr_end_flags: got %b expected 001", {underrun, busy, cmd_ready}); end
    endtask

    task automatic test_read();
        clear_mon();
        issue(1'b0, 20'h00020, 8'd1);
        cyc(12);
        n_checks++;
        if (ne_low !== 5) begin n_errors++; $display("FAIL rd_ne_low: got %0d expected 5", ne_low); end
        n_checks++;
        if (a_bad !== 0 || ctl_bad !== 0) begin n_errors++; $display("FAIL rd_addr_ctl: a_bad=%0d ctl_bad=%0d expected 0", a_bad, ctl_bad); end
        n_checks++;
        if (wq.size() !== 0) begin n_errors++; $display("FAIL rd_master_drove: got %0d cycles expected 0", wq.size()); end
        n_checks++;
        if (rq.size() !== 2) begin n_errors++; $display("FAIL rd_beats: got %0d expected 2", rq.size()); end
        else begin
            n_checks++;
            if (rq[0] !== 32'h120 || rq[1] !== 32'h121) begin n_errors++; $display("FAIL rd_data: got %h,%h expected 120,121", rq[0], rq[1]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        chk_ctl = 0;
        issue(1'b1, 20'h00030, 8'd1);
        cyc(2);
        cmd_write = 1'b0; cmd_addr = 20'h00040; cmd_len = 8'd1; cmd_valid = 1'b1;
        cyc(22);
        n_checks++;
        if (n_acc !== 2) begin n_errors++; $display("FAIL b2b_accepts: got %0d expected 2", n_acc); end
        n_checks++;
        if (gap_q.size() !== 1) begin n_errors++; $display("FAIL b2b_gaps: got %0d expected 1", gap_q.size()); end
        else begin
            n_checks++;
            if (gap_q[0] !== int'(GAP) + 1) begin n_errors++; $display("FAIL b2b_gap_len: got %0d expected %0d", gap_q[0], GAP + 1); end
        end
        n_checks++;
        if (ne_low !== 10) begin n_errors++; $display("FAIL b2b_ne_low: got %0d expected 10", ne_low); end
        n_checks++;
        if (rq.size() !== 2) begin n_errors++; $display("FAIL b2b_rd_beats: got %0d expected 2", rq.size()); end
        else begin
            n_checks++;
            if (rq[0] !== 32'h140 || rq[1] !== 32'h141) begin n_errors++; $display("FAIL b2b_rd_data: got %h,%h expected 140,141", rq[0], rq[1]); end
        end
    endtask

    task automatic test_underrun();
        clear_mon();
        skip_idx = 2;
        issue(1'b1, 20'h00050, 8'd3);
        cyc(14);
        n_checks++;
        if (wq.size() !== 4) begin n_errors++; $display("FAIL ur_beats: got %0d expected 4", wq.size()); end
        else begin
            n_checks++;
            if (wq[0] !== 32'hA0 || wq[1] !== 32'hA1 || wq[2] !== 32'hA1 || wq[3] !== 32'hA3) begin
                n_errors++; $display("FAIL ur_data: got %h,%h,%h,%h expected a0,a1,a1,a3", wq[0], wq[1], wq[2], wq[3]);
            end
        end
        n_checks++;
        if (underrun !== 1'b1) begin n_errors++; $display("FAIL ur_set: got %b expected 1", underrun); end
        clear_mon();
        issue(1'b0, 20'h00060, 8'd0);
        cyc(2);
        n_checks++;
        if (underrun !== 1'b0) begin n_errors++; $display("FAIL ur_clear: got %b expected 0", underrun); end
        cyc(10);
    endtask

    task automatic test_async_reset();
        clear_mon();
        issue(1'b1, 20'h00070, 8'd7);
        cyc(5);
        n_checks++;
        if (fmc_ne !== 1'b0 || !driven(fmc_d)) begin n_errors++; $display("FAIL ar_pre: ne=%b d=%h expected ne=0 driven", fmc_ne, fmc_d); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({fmc_ne, fmc_nwe, fmc_noe} !== 3'b111 || driven(fmc_d)) begin n_errors++; $display("FAIL ar_bus: ctl=%b d=%h expected 111 z", {fmc_ne, fmc_nwe, fmc_noe}, fmc_d); end
        n_checks++;
        if ({wr_ready, busy} !== 2'b00) begin n_errors++; $display("FAIL ar_flags: got %b expected 00", {wr_ready, busy}); end
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        n_checks++;
        if ({cmd_ready, busy} !== 2'b10) begin n_errors++; $display("FAIL ar_release: ready,busy=%b expected 10", {cmd_ready, busy}); end
        clear_mon();
        cyc(20);
        n_checks++;
        if (ne_low !== 0 || wq.size() !== 0) begin n_errors++; $display("FAIL ar_no_resume: ne_low=%0d beats=%0d expected 0", ne_low, wq.size()); end
    endtask

    task automatic test_len_bounds();
        int bad;
        clear_mon();
        issue(1'b0, 20'h00060, 8'd0);
        cyc(10);
        n_checks++;
        if (ne_low !== int'(RD_LAT) + 1) begin n_errors++; $display("FAIL len0_ne_low: got %0d expected %0d", ne_low, RD_LAT + 1); end
        n_checks++;
        if (rq.size() !== 1) begin n_errors++; $display("FAIL len0_beats: got %0d expected 1", rq.size()); end
        else begin
            n_checks++;
            if (rq[0] !== 32'h160) begin n_errors++; $display("FAIL len0_data: got %h expected 160", rq[0]); end
        end
        clear_mon();
        issue(1'b0, 20'h00100, 8'd255);
        cyc(270);
        n_checks++;
        if (ne_low !== int'(RD_LAT) + 256) begin n_errors++; $display("FAIL len255_ne_low: got %0d expected %0d", ne_low, RD_LAT + 256); end
        n_checks++;
        if (rq.size() !== 256) begin n_errors++; $display("FAIL len255_beats: got %0d expected 256", rq.size()); end
        else begin
            bad = 0;
            for (int i = 0; i < 256; i++) if (rq[i] !== DW'(32'h200 + 32'(i))) bad++;
            n_checks++;
            if (bad !== 0) begin n_errors++; $display("FAIL len255_data: %0d wrong beats, first %h last %h expected 200..2ff", bad, rq[0], rq[255]); end
        end
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; prev_rdy = 1'b0;
        exp_a = '0; exp_nwe = 1'b1; exp_noe = 1'b1;
        clear_mon();
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_underrun();
        test_async_reset();
        test_len_bounds();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
